// File: rtl/patch_ctrl_pkg.sv
// patch_ctrl_pkg: shared constants for the patch control unit.
//   - config field indices within a channel's address window
//   - cmd field bit positions
//   - per-channel FSM state encodings
package patch_ctrl_pkg;

    localparam logic [2:0] FLD_OBS_MASK    = 3'd0;
    localparam logic [2:0] FLD_OBS_PATTERN = 3'd1;
    localparam logic [2:0] FLD_CTRL_MASK   = 3'd2;
    localparam logic [2:0] FLD_CTRL_VALUE  = 3'd3;
    localparam logic [2:0] FLD_THRESHOLD   = 3'd4;
    localparam logic [2:0] FLD_DURATION    = 3'd5;
    localparam logic [2:0] FLD_CMD         = 3'd6;

    localparam int unsigned CMD_ARM_BIT    = 0;
    localparam int unsigned CMD_DISARM_BIT = 1;

    typedef logic [1:0] ch_state_t;
    localparam ch_state_t ST_IDLE   = 2'd0;
    localparam ch_state_t ST_ARMED  = 2'd1;
    localparam ch_state_t ST_ACTIVE = 2'd2;

endpackage

// File: rtl/patch_trigger_ch.sv
// patch_trigger_ch: one trigger channel (config registers, FSM, counters).
// Optional macro PATCH_CTRL_CHAIN_EN adds chain_first/prev_fired inputs that gate
// hit evaluation on the previous channel having fired since this one was armed.
// Ports:
//   clk, rst               clock, async active-high reset
//   observe_port           observed bus
//   wr_en/wr_field/wr_data config write already decoded to this channel
//   active                 channel is overriding (combinational from state)
//   fired                  one-cycle pulse in the first ACTIVE cycle
//   ctrl_mask/ctrl_value   override mask and value
module patch_trigger_ch
    import patch_ctrl_pkg::*;
#(
    parameter int unsigned OBS_W  = 8,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OBS_W-1:0]  observe_port,
    input  logic              wr_en,
    input  logic [2:0]        wr_field,
    input  logic [DATA_W-1:0] wr_data,
`ifdef PATCH_CTRL_CHAIN_EN
    input  logic              chain_first,
    input  logic              prev_fired,
`endif
    output logic              active,
    output logic              fired,
    output logic [CTRL_W-1:0] ctrl_mask,
    output logic [CTRL_W-1:0] ctrl_value
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [OBS_W-1:0]  obs_mask_q, obs_pattern_q;
    logic [CTRL_W-1:0] ctrl_mask_q, ctrl_value_q;
    logic [CNT_W-1:0]  threshold_q, duration_q;
    logic [CNT_W-1:0]  match_q, match_d, dur_q, dur_d;
    ch_state_t         state_q, state_d;
    logic              fired_q, fired_d;
    logic              arm, disarm, hit, hit_en, reach;
    logic [CNT_W-1:0]  thr_eff;
    logic              unused_wdata;

    assign unused_wdata = ^wr_data;

    assign disarm = wr_en && (wr_field == FLD_CMD) && wr_data[CMD_DISARM_BIT];
    assign arm    = wr_en && (wr_field == FLD_CMD) && wr_data[CMD_ARM_BIT] && !disarm;
    assign hit    = ((observe_port ^ obs_pattern_q) & obs_mask_q) == '0;

`ifdef PATCH_CTRL_CHAIN_EN
    logic prev_fired_q;
    assign hit_en = chain_first || prev_fired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  prev_fired_q <= 1'b0;
        else if (arm || disarm)   prev_fired_q <= 1'b0;
        else if (prev_fired)      prev_fired_q <= 1'b1;
    end
`else
    assign hit_en = 1'b1;
`endif

    // Threshold 0 behaves as 1; compare one bit wider so the +1 cannot wrap.
    assign thr_eff = (threshold_q == '0) ? CNT_ONE : threshold_q;
    assign reach   = ({1'b0, match_q} + {1'b0, CNT_ONE}) >= {1'b0, thr_eff};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obs_mask_q    <= '0;
            obs_pattern_q <= '0;
            ctrl_mask_q   <= '0;
            ctrl_value_q  <= '0;
            threshold_q   <= '0;
            duration_q    <= '0;
        end else if (wr_en) begin
            case (wr_field)
                FLD_OBS_MASK:    obs_mask_q    <= wr_data[OBS_W-1:0];
                FLD_OBS_PATTERN: obs_pattern_q <= wr_data[OBS_W-1:0];
                FLD_CTRL_MASK:   ctrl_mask_q   <= wr_data[CTRL_W-1:0];
                FLD_CTRL_VALUE:  ctrl_value_q  <= wr_data[CTRL_W-1:0];
                FLD_THRESHOLD:   threshold_q   <= wr_data[CNT_W-1:0];
                FLD_DURATION:    duration_q    <= wr_data[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        dur_d   = dur_q;
        fired_d = 1'b0;
        if (disarm) begin
            state_d = ST_IDLE;
            match_d = '0;
            dur_d   = '0;
        end else if (arm) begin
            // Arm always wins over a hit in the same cycle.
            state_d = ST_ARMED;
            match_d = '0;
            dur_d   = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (hit_en && hit) begin
                        match_d = (&match_q) ? match_q : match_q + CNT_ONE;
                        if (reach) begin
                            state_d = ST_ACTIVE;
                            dur_d   = '0;
                            fired_d = 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Duration 0 is sticky: counter free-runs, exit only via disarm.
                    if ((duration_q != '0) && (dur_q == duration_q - CNT_ONE)) begin
                        state_d = ST_IDLE;
                    end else begin
                        dur_d = dur_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            match_q <= '0;
            dur_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            dur_q   <= dur_d;
            fired_q <= fired_d;
        end
    end

    assign active     = (state_q == ST_ACTIVE);
    assign fired      = fired_q;
    assign ctrl_mask  = ctrl_mask_q;
    assign ctrl_value = ctrl_value_q;

endmodule

// File: rtl/patch_control_unit.sv
// patch_control_unit: NUM_CH trigger channels that override selected control bits.
// Optional macro PATCH_CTRL_CHAIN_EN: channel i>0 only evaluates hits after
// channel i-1 has fired since i was last armed.
// Ports:
//   clk, rst           clock, async active-high reset
//   observe_port       observed bus from patched modules
//   control_port_in    natural control values
//   control_port_out   control values after override (combinational mux)
//   cfg_we/addr/wdata  config write, addr = {channel, field[2:0]}
//   active             per-channel override active
//   fired              per-channel pulse on entry to ACTIVE
module patch_control_unit
    import patch_ctrl_pkg::*;
#(
    parameter int unsigned OBS_W  = 8,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OBS_W-1:0]          observe_port,
    input  logic [CTRL_W-1:0]         control_port_in,
    output logic [CTRL_W-1:0]         control_port_out,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)+2:0] cfg_addr,
    input  logic [DATA_W-1:0]         cfg_wdata,
    output logic [NUM_CH-1:0]         active,
    output logic [NUM_CH-1:0]         fired
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [CTRL_W-1:0] ch_mask  [NUM_CH];
    logic [CTRL_W-1:0] ch_value [NUM_CH];
    logic [CH_W-1:0]   ch_sel;
    logic [2:0]        field;

    assign ch_sel = cfg_addr[CH_W+2:3];
    assign field  = cfg_addr[2:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = cfg_we && (ch_sel == CH_W'(i));
`ifdef PATCH_CTRL_CHAIN_EN
        logic prev_fired;
        if (i == 0) begin : g_first
            assign prev_fired = 1'b0;
        end else begin : g_rest
            assign prev_fired = fired[i-1];
        end
`endif
        patch_trigger_ch #(
            .OBS_W  (OBS_W),
            .CTRL_W (CTRL_W),
            .CNT_W  (CNT_W),
            .DATA_W (DATA_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .observe_port (observe_port),
            .wr_en        (wr_en),
            .wr_field     (field),
            .wr_data      (cfg_wdata),
`ifdef PATCH_CTRL_CHAIN_EN
            .chain_first  (i == 0),
            .prev_fired   (prev_fired),
`endif
            .active       (active[i]),
            .fired        (fired[i]),
            .ctrl_mask    (ch_mask[i]),
            .ctrl_value   (ch_value[i])
        );
    end

    // Apply from highest index down so the lowest-index active channel wins per bit.
    always_comb begin
        control_port_out = control_port_in;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (active[i]) begin
                control_port_out = (control_port_out & ~ch_mask[i]) | (ch_value[i] & ch_mask[i]);
            end
        end
    end

endmodule

// File: tb/tb_patch_control_unit.sv
// tb_patch_control_unit: directed stimulus, a behavioural reference model checked
// every negedge, plus hand-computed literal expectations.
module tb_patch_control_unit;

    localparam int OBS_W  = 8;
    localparam int CTRL_W = 8;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int DATA_W = 32;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [OBS_W-1:0]  observe_port;
    logic [CTRL_W-1:0] control_port_in;
    logic [CTRL_W-1:0] control_port_out;
    logic              cfg_we;
    logic [4:0]        cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] fired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    patch_control_unit #(
        .OBS_W  (OBS_W),
        .CTRL_W (CTRL_W),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .observe_port     (observe_port),
        .control_port_in  (control_port_in),
        .control_port_out (control_port_out),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .active           (active),
        .fired            (fired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 armed, 2 active
    int         m_mode  [NUM_CH];
    int         m_hits  [NUM_CH];
    int         m_el    [NUM_CH];
    int         m_thr   [NUM_CH];
    int         m_dur   [NUM_CH];
    logic [7:0] m_omask [NUM_CH];
    logic [7:0] m_opat  [NUM_CH];
    logic [7:0] m_cmask [NUM_CH];
    logic [7:0] m_cval  [NUM_CH];
    bit         m_fired [NUM_CH];
    bit         m_prev  [NUM_CH];
    bit         pf_snap [NUM_CH];
    bit         w_sel, w_arm, w_dis, w_en, w_hit;

    always @(posedge clk or posedge rst) begin : model
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0; m_hits[c] = 0; m_el[c] = 0; m_thr[c] = 0; m_dur[c] = 0;
                m_omask[c] = 0; m_opat[c] = 0; m_cmask[c] = 0; m_cval[c] = 0;
                m_fired[c] = 0; m_prev[c] = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) pf_snap[c] = m_fired[c];
            for (int c = 0; c < NUM_CH; c++) begin
                w_sel = cfg_we && (int'(cfg_addr[4:3]) == c);
                w_dis = w_sel && (cfg_addr[2:0] == 3'd6) && cfg_wdata[1];
                w_arm = w_sel && (cfg_addr[2:0] == 3'd6) && cfg_wdata[0] && !cfg_wdata[1];
                w_hit = ((observe_port ^ m_opat[c]) & m_omask[c]) == 8'h00;
`ifdef PATCH_CTRL_CHAIN_EN
                w_en = (c == 0) || m_prev[c];
`else
                w_en = 1'b1;
`endif
                m_fired[c] = 0;
                if (w_dis || w_arm) begin
                    m_mode[c] = w_dis ? 0 : 1;
                    m_hits[c] = 0;
                    m_el[c]   = 0;
                end else if (m_mode[c] == 1) begin
                    if (w_en && w_hit) begin
                        if (m_hits[c] < CNT_MAX) m_hits[c]++;
                        if (m_hits[c] >= ((m_thr[c] == 0) ? 1 : m_thr[c])) begin
                            m_mode[c]  = 2;
                            m_el[c]    = 0;
                            m_fired[c] = 1;
                        end
                    end
                end else if (m_mode[c] == 2) begin
                    if (m_dur[c] != 0 && m_el[c] == m_dur[c] - 1) m_mode[c] = 0;
                    else m_el[c] = (m_el[c] + 1) % (CNT_MAX + 1);
                end
`ifdef PATCH_CTRL_CHAIN_EN
                if (w_dis || w_arm) m_prev[c] = 0;
                else if (c > 0 && pf_snap[c-1]) m_prev[c] = 1;
`endif
                if (w_sel) begin
                    case (cfg_addr[2:0])
                        3'd0: m_omask[c] = cfg_wdata[7:0];
                        3'd1: m_opat[c]  = cfg_wdata[7:0];
                        3'd2: m_cmask[c] = cfg_wdata[7:0];
                        3'd3: m_cval[c]  = cfg_wdata[7:0];
                        3'd4: m_thr[c]   = int'(cfg_wdata[15:0]);
                        3'd5: m_dur[c]   = int'(cfg_wdata[15:0]);
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [NUM_CH-1:0] e_act, e_fired;
    logic [7:0]        e_out;

    always @(negedge clk) begin : compare
        for (int c = 0; c < NUM_CH; c++) begin
            e_act[c]   = (m_mode[c] == 2);
            e_fired[c] = m_fired[c];
        end
        for (int b = 0; b < CTRL_W; b++) begin
            e_out[b] = control_port_in[b];
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_mode[c] == 2 && m_cmask[c][b]) begin
                    e_out[b] = m_cval[c][b];
                    break;
                end
            end
        end
        check("model_active", 32'(active), 32'(e_act));
        check("model_fired", 32'(fired), 32'(e_fired));
        check("model_out", 32'(control_port_out), 32'(e_out));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int fld, input logic [31:0] d);
        logic [1:0] c2;
        logic [2:0] f3;
        c2 = 2'(ch);
        f3 = 3'(fld);
        cfg_we    = 1'b1;
        cfg_addr  = {c2, f3};
        cfg_wdata = d;
        step(1);
        cfg_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        observe_port = 8'h00;
        control_port_in = 8'hA5;
        #12;
        check("reset_out", 32'(control_port_out), 32'hA5);
        check("reset_active", 32'(active), 32'h0);
        check("reset_fired", 32'(fired), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3);

        // Pass-through is combinational
        control_port_in = 8'h5A;
        #1 check("pass_comb", 32'(control_port_out), 32'h5A);
        control_port_in = 8'hA5;
        #1 check("pass_comb2", 32'(control_port_out), 32'hA5);
        step(1);

        // Threshold 3, duration 4, misses do not reset count
        wr(0, 0, 32'h0F); wr(0, 1, 32'h03); wr(0, 4, 3); wr(0, 5, 4);
        wr(0, 2, 32'hF0); wr(0, 3, 32'h50); wr(0, 6, 1);
        observe_port = 8'h13; step(1);
        observe_port = 8'h00; step(1);
        observe_port = 8'h23; step(1);
        check("two_hits_idle", 32'(active), 32'h0);
        observe_port = 8'h33; step(1);
        check("fired0", 32'(fired), 32'h1);
        observe_port = 8'h00;
        for (int i = 0; i < 4; i++) begin
            check("ovr_0x55", 32'(control_port_out), 32'h55);
            if (i == 1) check("fired_one_cycle", 32'(fired), 32'h0);
            step(1);
        end
        check("ovr_end", 32'(control_port_out), 32'hA5);
        check("ch0_idle", 32'(active), 32'h0);

        // Sticky duration on ch1
        wr(1, 4, 1); wr(1, 5, 0); wr(1, 2, 32'h01); wr(1, 3, 32'h00); wr(1, 6, 1);
        step(1);
        for (int i = 0; i < 20; i++) begin
            check("sticky", 32'(control_port_out), 32'hA4);
            step(1);
        end
        wr(1, 6, 2);
        check("sticky_release", 32'(control_port_out), 32'hA5);

        // Priority: lower index wins
        wr(0, 0, 0); wr(0, 2, 32'hFF); wr(0, 3, 32'h11); wr(0, 4, 1); wr(0, 5, 0);
        wr(1, 2, 32'hFF); wr(1, 3, 32'h22);
        wr(0, 6, 1); wr(1, 6, 1);
        step(2);
        check("prio_both", 32'(control_port_out), 32'h11);
        check("prio_active", 32'(active), 32'h3);
        wr(0, 6, 2);
        check("prio_ch1", 32'(control_port_out), 32'h22);
        wr(1, 6, 3);  // disarm wins over arm
        check("prio_none", 32'(control_port_out), 32'hA5);

        // Threshold 0 acts as 1; duration 1; arm cycle counts no hit
        wr(2, 2, 32'h0F); wr(2, 3, 32'h0A); wr(2, 4, 0); wr(2, 5, 1);
        wr(2, 6, 1);
        check("arm_no_hit", 32'(active), 32'h0);
        step(1);
        check("thr0_out", 32'(control_port_out), 32'hAA);
        check("thr0_active", 32'(active), 32'h4);
        step(1);
        check("dur1_end", 32'(control_port_out), 32'hA5);

        // Async reset mid-override
        wr(0, 6, 1);
        step(1);
        check("pre_rst_ovr", 32'(control_port_out), 32'h11);
        #1 rst = 1'b1;
        #1 check("rst_out", 32'(control_port_out), 32'hA5);
        check("rst_active", 32'(active), 32'h0);
        control_port_in = 8'h3C;
        #1 check("rst_out_comb", 32'(control_port_out), 32'h3C);
        control_port_in = 8'hA5;
        @(posedge clk);
        #1 rst = 1'b0;
        step(3);
        check("post_rst_idle", 32'(active), 32'h0);
        wr(0, 2, 32'hFF); wr(0, 3, 32'h11); wr(0, 5, 0);
        step(3);
        check("needs_rearm", 32'(control_port_out), 32'hA5);
        wr(0, 6, 1);
        step(1);
        check("rearm_ovr", 32'(control_port_out), 32'h11);
        wr(0, 6, 2);
        step(1);

`ifdef PATCH_CTRL_CHAIN_EN
        begin : chain_test
            bit seen;
            wr(0, 0, 32'hFF); wr(0, 1, 32'h11); wr(0, 4, 1); wr(0, 5, 1); wr(0, 2, 0);
            wr(1, 0, 32'hFF); wr(1, 1, 32'h22); wr(1, 4, 1); wr(1, 5, 2);
            wr(1, 2, 32'h0F); wr(1, 3, 0);
            observe_port = 8'h22;
            wr(0, 6, 1); wr(1, 6, 1);
            step(4);
            check("chain_blocked", 32'(active[1]), 32'h0);
            observe_port = 8'h11;
            step(1);
            check("chain_fired0", 32'(fired[0]), 32'h1);
            observe_port = 8'h22;
            seen = 1'b0;
            for (int i = 0; i < 6 && !seen; i++) begin
                step(1);
                if (fired[1]) seen = 1'b1;
            end
            check("chain_fired1", 32'(seen), 32'h1);
            wr(0, 6, 2); wr(1, 6, 2);
            observe_port = 8'h00;
            step(1);
        end
`endif

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
